// File: rtl/seq_mul_ctrl.sv
// Shift-and-add unsigned multiplier controller driving an external Width-bit adder.
// One product bit retires per RUN cycle; the product is held on P until the next accept.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand pair
// RUN   | one add/shift step per cycle, Width cycles total
// DONE  | product just registered on P, done pulse, back to IDLE
module seq_mul_ctrl #(
    parameter int Width = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Width-1:0]     A_in,
    input  logic [Width-1:0]     B_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*Width-1:0]   P,
    output logic [Width-1:0]     add_a,
    output logic [Width-1:0]     add_b,
    output logic                 add_ci,
    input  logic [Width-1:0]     add_s,
    input  logic                 add_co
);

    localparam int CntW = $clog2(Width) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [Width-1:0]     hi;
    logic [Width-1:0]     lo;
    logic [Width-1:0]     mcand;
    logic [CntW-1:0]      cnt;
    logic [2*Width-1:0]   step_nxt;

    // The adder carry lands in hi[Width-1] as the whole pair shifts right by one.
    assign step_nxt = {add_co, add_s, lo[Width-1:1]};

    assign add_a  = (state == RUN) ? hi : '0;
    assign add_b  = (state == RUN && lo[0]) ? mcand : '0;
    assign add_ci = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            cnt      <= '0;
            P        <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= A_in;
                        lo       <= B_in;
                        hi       <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    {hi, lo} <= step_nxt;
                    cnt      <= cnt + CntW'(1);
                    if (cnt == CntLast) begin
                        P     <= step_nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Bench for seq_mul_ctrl: an 8-bit and a 64-bit instance share one stimulus stream,
// each with its own arithmetic/timing reference model and scoreboard.
module tb_seq_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] a_drv = '0;
    logic [63:0] b_drv = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int W = (gi == 0) ? 8 : 64;

        logic             ready, busy, done, ci, co;
        logic [W-1:0]     add_a, add_b, add_s;
        logic [2*W-1:0]   p;

        // Behavioural stand-in for the external adder.
        assign {co, add_s} = {1'b0, add_a} + {1'b0, add_b} + (W+1)'(ci);

        seq_mul_ctrl #(.Width(W)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (ready),
            .A_in     (a_drv[W-1:0]),
            .B_in     (b_drv[W-1:0]),
            .busy     (busy),
            .done     (done),
            .P        (p),
            .add_a    (add_a),
            .add_b    (add_b),
            .add_ci   (ci),
            .add_s    (add_s),
            .add_co   (co)
        );

        // Reference model: accept whenever idle, result = a*b after W+1 edges, idle again after W+2.
        logic [127:0] prod_q[$];
        int           done_q[$];
        bit           bz_q[$];
        int           ready_at = 0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_q.delete();
                done_q.delete();
                bz_q.delete();
                ready_at = 0;
            end else if (in_valid && cyc >= ready_at) begin
                prod_q.push_back(128'(a_drv[W-1:0]) * 128'(b_drv[W-1:0]));
                done_q.push_back(cyc + 1 + W);
                bz_q.push_back(b_drv[W-1:0] == '0);
                ready_at = cyc + W + 2;
            end
        end

        logic [127:0] last_p = '0;
        bit           prev_done = 1'b0;

        always @(negedge clk) begin : mon
            bit exp_ready;
            if (!rst_n) begin
                last_p    = '0;
                prev_done = 1'b0;
            end else begin
                exp_ready = (cyc >= ready_at);
                chk($sformatf("in_ready[w%0d]", W), 128'(ready), 128'(exp_ready));
                chk($sformatf("busy[w%0d]", W), 128'(busy), 128'(!exp_ready));
                chk($sformatf("add_ci[w%0d]", W), 128'(ci), 128'(0));
                if (exp_ready) begin
                    chk($sformatf("add_a_idle[w%0d]", W), 128'(add_a), 128'(0));
                    chk($sformatf("add_b_idle[w%0d]", W), 128'(add_b), 128'(0));
                end else if (bz_q.size() > 0 && bz_q[0]) begin
                    chk($sformatf("add_b_bzero[w%0d]", W), 128'(add_b), 128'(0));
                end
                if (done_q.size() > 0 && done_q[0] == cyc) begin
                    chk($sformatf("done[w%0d]", W), 128'(done), 128'(1));
                    chk($sformatf("product[w%0d]", W), 128'(p), prod_q[0]);
                    last_p = prod_q[0];
                    void'(prod_q.pop_front());
                    void'(done_q.pop_front());
                    void'(bz_q.pop_front());
                end else begin
                    chk($sformatf("done_low[w%0d]", W), 128'(done), 128'(0));
                    chk($sformatf("p_hold[w%0d]", W), 128'(p), last_p);
                end
                chk($sformatf("done_twice[w%0d]", W), 128'(prev_done && done), 128'(0));
                prev_done = done;
            end
        end
    end

    function automatic bit both_idle();
        return g[0].prod_q.size() == 0 && cyc >= g[0].ready_at &&
               g[1].prod_q.size() == 0 && cyc >= g[1].ready_at;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!both_idle() && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!both_idle()) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", n);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        wait_idle();
        a_drv    = a;
        b_drv    = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a_drv    = {$urandom, $urandom};
        b_drv    = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 64'(1);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("reset_p", i == 0 ? 128'(g[0].p) : 128'(g[1].p), 128'(0));
            chk("reset_done", i == 0 ? 128'(g[0].done) : 128'(g[1].done), 128'(0));
            chk("reset_busy", i == 0 ? 128'(g[0].busy) : 128'(g[1].busy), 128'(0));
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(64'd3, 64'd5);
        issue('1, '1);
        issue(64'h1234, 64'd0);
        issue(64'd0, 64'h1234);

        // Operands offered while busy must be ignored until in_ready returns.
        issue(64'd3, 64'd5);
        a_drv    = 64'd7;
        b_drv    = 64'd9;
        in_valid = 1'b1;
        repeat (70) @(negedge clk);
        in_valid = 1'b0;
        wait_idle();

        // Reset in the middle of RUN (counter at 3) aborts the operation.
        issue(64'h55, 64'h33);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_p8", 128'(g[0].p), 128'(0));
        chk("abort_p64", 128'(g[1].p), 128'(0));
        chk("abort_busy8", 128'(g[0].busy), 128'(0));
        chk("abort_busy64", 128'(g[1].busy), 128'(0));
        chk("abort_done8", 128'(g[0].done), 128'(0));
        chk("abort_adda64", 128'(g[1].add_a), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(64'hA5, 64'h3C);

        // Back-to-back with in_valid held high.
        wait_idle();
        a_drv    = 64'd6;
        b_drv    = 64'd7;
        in_valid = 1'b1;
        repeat (200) @(negedge clk);
        in_valid = 1'b0;
        wait_idle();

        // Random traffic: operands change every cycle, only accept-edge values matter.
        repeat (400) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a_drv    = pick();
            b_drv    = pick();
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
